// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register indices, widths and reset values.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_GP   = 28;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_RA   = 31;

  localparam logic [WORD_W-1:0] SP_INIT_DEF = 32'h7FFF_EFFC;
  localparam logic [WORD_W-1:0] GP_INIT_DEF = 32'h1000_8000;

endpackage

// File: rtl/mips_register_file_if.sv
// Register-file access bundle: two read ports, one write port, one debug read port.
interface mips_register_file_if
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
);

  logic [REG_ADDR_W-1:0] ra_addr;
  logic [REG_ADDR_W-1:0] rb_addr;
  logic [WIDTH-1:0]      ra_data;
  logic [WIDTH-1:0]      rb_data;
  logic                  we;
  logic [REG_ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]      w_data;
  logic [REG_ADDR_W-1:0] dbg_addr;
  logic [WIDTH-1:0]      dbg_data;

  modport master (
    output ra_addr, rb_addr, we, w_addr, w_data, dbg_addr,
    input  ra_data, rb_data, dbg_data
  );

  modport slave (
    input  ra_addr, rb_addr, we, w_addr, w_data, dbg_addr,
    output ra_data, rb_data, dbg_data
  );

endinterface

// File: rtl/mips_register_file_reg_word_en.sv
// One storage word with load enable and asynchronous active-high reset to RESET_VAL.
module reg_word_en #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mips_register_file.sv
// 32 x WIDTH MIPS general-purpose register file: two combinational read ports,
// one clocked write port, a never-bypassed debug read port; r0 is hard-wired to 0.
module mips_register_file
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH   = WORD_W,
  parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(SP_INIT_DEF),
  parameter logic [WIDTH-1:0] GP_INIT = WIDTH'(GP_INIT_DEF),
  parameter bit               BYPASS  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_register_file_if.slave  rf
);

  logic [NUM_REGS-1:0] wr_en;
  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [WIDTH-1:0]    ra_data_c;
  logic [WIDTH-1:0]    rb_data_c;

  // One-hot write decode; r0 never enabled, and reset suppresses writes and bypass.
  always_comb begin
    wr_en = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      wr_en[i] = rf.we && !rst && (rf.w_addr == REG_ADDR_W'(i));
    end
    wr_en[REG_ZERO] = 1'b0;
  end

  assign regs[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    localparam logic [WIDTH-1:0] RV = (g == REG_SP) ? SP_INIT :
                                      (g == REG_GP) ? GP_INIT : '0;
    reg_word_en #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RV)
    ) u_word (
      .clk (clk),
      .rst (rst),
      .en  (wr_en[g]),
      .d   (rf.w_data),
      .q   (regs[g])
    );
  end

  // Read muxes; wr_en already excludes r0 so bypass can never leak into index 0.
  always_comb begin
    ra_data_c = regs[rf.ra_addr];
    rb_data_c = regs[rf.rb_addr];
    if (BYPASS && wr_en[rf.ra_addr]) ra_data_c = rf.w_data;
    if (BYPASS && wr_en[rf.rb_addr]) rb_data_c = rf.w_data;
  end

  assign rf.ra_data  = ra_data_c;
  assign rf.rb_data  = rb_data_c;
  assign rf.dbg_data = regs[rf.dbg_addr];

endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32 x 32-bit MIPS general-purpose register file for the single-cycle datapath.
- Sits directly upstream of the 32-bit ALU built from the one-bit slices:
  - read port A supplies ALU input a (rs);
  - read port B supplies ALU input b (rt) ahead of the immediate mux.
- The single write port takes the write-back result (ALU R, memory load data or link address) at the end of each instruction cycle.

Parameters:
- WIDTH, 32, data width of every register.
- SP_INIT, 32'h7FFF_EFFC, value loaded into r29 ($sp) on reset.
- GP_INIT, 32'h1000_8000, value loaded into r28 ($gp) on reset.
- BYPASS, 0, 1 = write-through forwarding from the write port to the read ports in the same cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- ra_addr  input  5  read port A register index (rs).
- rb_addr  input  5  read port B register index (rt).
- ra_data  output  WIDTH  read port A data, to ALU a.
- rb_data  output  WIDTH  read port B data, to ALU b / store data.
- we  input  1  write enable (RegWrite).
- w_addr  input  5  write index (rd, rt or 31 after RegDst mux).
- w_data  input  WIDTH  write-back data.
- dbg_addr  input  5  debug/testbench read index.
- dbg_data  output  WIDTH  debug read data (combinational, never bypassed).

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous and active-high.
- Reset:
  - Asserting `rst` immediately, without waiting for a clock edge, sets r1..r27, r30 and r31 to 0, r28 to GP_INIT and r29 to SP_INIT.
  - Reset dominates `we`: a write presented in a cycle where `rst` is high is discarded.
  - Deasserting `rst` between edges takes effect at the next rising edge; there is no synchronous-release logic in the block.
- Reads:
  - Purely combinational; zero-cycle latency from address to data.
  - Reading any index returns its current stored value.
  - Index 0 always returns 0 on all three read ports.
- Write:
  - On a rising `clk` edge with `we`=1, `rst`=0 and `w_addr`!=0, register[w_addr] <= w_data.
  - Writes to index 0 are dropped; r0 has no storage.
  - `we`=0 leaves all registers unchanged.
- Bypass:
  - BYPASS=0: a read of the register being written returns the old value until the edge, and the new value immediately after it.
  - BYPASS=1: if `we`=1, `w_addr`!=0 and `w_addr`==ra_addr, then ra_data = w_data combinationally. Port B behaves the same way.
  - BYPASS never applies to index 0 or to `dbg_data`.
- Simultaneous events:
  - Read A, read B and the write may all target the same index; both read ports then return the same value, following the bypass rule.
  - ra_addr==rb_addr is legal.
- Outputs during reset:
  - `ra_data`, `rb_data` and `dbg_data` reflect the reset contents: 0, SP_INIT or GP_INIT according to the index.
- Unknown or X address inputs are not tolerated; the bench must keep them driven.
- No internal state other than the 31 storage registers; no state machine.

Decomposition:
- Shared package `mips_pkg`:
  - REG_ZERO=0, REG_GP=28, REG_SP=29, REG_RA=31;
  - REG_ADDR_W=5, WORD_W=32;
  - default SP_INIT/GP_INIT constants.
- The ALU control and write-back mux reuse the same package.
- Sub-module `reg_word_en`:
  - one WIDTH-bit register with asynchronous active-high reset to a parameterised RESET_VAL, plus a load enable;
  - instantiated 31 times with per-index RESET_VAL.
- Write decode (5-to-32 one-hot ANDed with `we`, bit 0 forced low) and the three 32:1 read muxes are written in this module.

Test Plan:
1. Reset values: pulse `rst` mid-cycle (not on a clock edge), then sweep `dbg_addr` 0..31 -> 0 everywhere except dbg[28]=32'h1000_8000 and dbg[29]=32'h7FFF_EFFC. The values must appear before the next edge.
2. Write/read and r0 immunity: write 32'hDEAD_BEEF to r8; write 32'hFFFF_FFFF to r0 with `we`=1; set ra_addr=8, rb_addr=0 -> ra_data=DEADBEEF, rb_data=0; dbg[0]=0.
3. Same-cycle read of the write target:
   - BYPASS=0: r9=5, then present we=1, w_addr=9, w_data=7, ra_addr=9 -> ra_data=5 before the edge, 7 after it.
   - BYPASS=1: same stimulus -> ra_data=7 before the edge; dbg[9]=5 before the edge.
4. Write gating: we=0, w_addr=10, w_data=1234 for 3 edges -> r10 stays 0. Then we=1 for one edge -> r10=1234, and every other register is unchanged (checked by dbg sweep).
5. Reset mid-operation: r31=32'h0040_0008, then assert `rst` while we=1, w_addr=31, w_data=99 across an edge -> r31=0 and r29=SP_INIT. Release `rst`; the next edge with we=1, w_addr=31, w_data=99 -> r31=99.
6. Dual-port independence: r1=11, r2=22, ra_addr=2, rb_addr=1 -> ra_data=22, rb_data=11. Set ra_addr=rb_addr=2 -> both 22.
